// File: rtl/sdram_line_slave.sv
// sdram_line_slave: terminates 4-beat Wishbone line bursts and turns each
// burst into a single 128-bit native line request to the SDRAM controller.
module sdram_line_slave #(
  parameter int AWIDTH = 25,
  parameter int DWIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [AWIDTH-1:0]     wb_adr_i,
  input  logic [DWIDTH-1:0]     wb_dat_i,
  input  logic [DWIDTH/8-1:0]   wb_sel_i,
  output logic [DWIDTH-1:0]     wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [AWIDTH-3:0]     mem_adr_o,
  output logic [4*DWIDTH-1:0]   mem_wdata_o,
  output logic [4*DWIDTH/8-1:0] mem_be_o,
  input  logic [4*DWIDTH-1:0]   mem_rdata_i,
  input  logic                  mem_ack_i
);
  localparam int SW = DWIDTH/8;

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_BEAT, WR_BEAT, WR_REQ
  } state_t;

  state_t              state_q, state_d;
  logic [AWIDTH-3:0]   line_q;
  logic [1:0]          start_q;
  logic [2:0]          cnt_q;
  logic                abort_q;
  logic [4*DWIDTH-1:0] buf_q;
  logic [4*SW-1:0]     mask_q;

  logic                beat;
  logic                start_go;
  logic                take;
  logic                cap;
  logic [1:0]          wsel;
  logic [2:0]          cnt_base;

  assign beat     = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign cnt_base = start_go ? 3'd0 : cnt_q;
  assign wsel     = start_go ? wb_adr_i[1:0]
                             : start_q + cnt_q[1:0];

  assign mem_adr_o   = line_q;
  assign mem_wdata_o = buf_q;
  assign mem_be_o    = mask_q;

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and per-cycle strobes (start, beat take, read capture).
  always_comb begin
    state_d  = state_q;
    start_go = 1'b0;
    take     = 1'b0;
    cap      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (beat) begin
          start_go = 1'b1;
          take     = wb_we_i;
          state_d  = wb_we_i ? WR_BEAT : RD_REQ;
        end
      end
      RD_REQ: begin
        if (mem_ack_i) begin
          cap     = ~abort_q & wb_cyc_i;
          state_d = (~abort_q & wb_cyc_i) ? RD_BEAT : IDLE;
        end
      end
      RD_BEAT: begin
        if (!wb_cyc_i) begin
          state_d = IDLE;
        end else if (beat) begin
          take = 1'b1;
          if (cnt_q == 3'd3) state_d = IDLE;
        end
      end
      WR_BEAT: begin
        if (!wb_cyc_i) begin
          state_d = (cnt_q == 3'd0) ? IDLE : WR_REQ;
        end else if (beat) begin
          take = 1'b1;
          if (cnt_q == 3'd3) state_d = WR_REQ;
        end
      end
      WR_REQ: begin
        if (mem_ack_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Line buffer, byte mask, beat counter and registered bus outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      line_q    <= '0;
      start_q   <= '0;
      cnt_q     <= '0;
      abort_q   <= 1'b0;
      buf_q     <= '0;
      mask_q    <= '0;
      wb_ack_o  <= 1'b0;
      wb_dat_o  <= '0;
      mem_req_o <= 1'b0;
      mem_we_o  <= 1'b0;
    end else begin
      wb_ack_o  <= take;
      wb_dat_o  <= '0;
      mem_req_o <= (state_q == RD_REQ || state_q == WR_REQ)
                   && !mem_ack_i;
      mem_we_o  <= (state_q == WR_REQ) && !mem_ack_i;
      if (start_go) begin
        line_q  <= wb_adr_i[AWIDTH-1:2];
        start_q <= wb_adr_i[1:0];
        mask_q  <= '0;
        abort_q <= 1'b0;
      end
      if (state_q == RD_REQ && !wb_cyc_i) abort_q <= 1'b1;
      if (cap) begin
        buf_q <= mem_rdata_i;
        cnt_q <= 3'd0;
      end
      if (take) begin
        cnt_q <= cnt_base + 3'd1;
        if (state_q == RD_BEAT) begin
          wb_dat_o <= buf_q[wsel*DWIDTH +: DWIDTH];
        end else begin
          buf_q[wsel*DWIDTH +: DWIDTH] <= wb_dat_i;
          mask_q[wsel*SW +: SW] <=
            (start_go ? {SW{1'b0}} : mask_q[wsel*SW +: SW])
            | wb_sel_i;
        end
      end
    end
  end

endmodule

// File: doc/sdram_line_slave.md
Name: sdram_line_slave

Overview:
- Wishbone slave that terminates the 4-beat line bursts issued by the SDRAM cache's memory-side master port (line fills = 4 reads, line flushes = 4 writes).
- Packs write beats into a 128-bit line buffer and commits them to the SDRAM controller's native line port in one request.
- Fetches a full line in one native request for reads, then serves it back beat by beat.
- Sits between the cache master port and the SDRAM controller core.

Parameters:
AWIDTH, 25, word address width of the Wishbone port.
DWIDTH, 32, Wishbone data width; a line is 4*DWIDTH bits.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset
wb_cyc_i  in  1  bus cycle; held for a whole burst
wb_stb_i  in  1  beat strobe
wb_we_i  in  1  write enable; sampled on the first beat only
wb_adr_i  in  AWIDTH  word address; sampled on the first beat only
wb_dat_i  in  DWIDTH  write data
wb_sel_i  in  DWIDTH/8  byte enables
wb_dat_o  out  DWIDTH  read data; valid while wb_ack_o=1
wb_ack_o  out  1  beat acknowledge, registered
mem_req_o  out  1  native line request
mem_we_o  out  1  1 = line write
mem_adr_o  out  AWIDTH-2  line address
mem_wdata_o  out  4*DWIDTH  line write data; word k at bits [k*DWIDTH +: DWIDTH]
mem_be_o  out  4*DWIDTH/8  line byte enables
mem_rdata_i  in  4*DWIDTH  line read data; valid with mem_ack_i
mem_ack_i  in  1  one-cycle completion pulse from the controller

Behaviour:
Clock and reset:
- Clock clk_i. Reset rst_i is asynchronous and active-high.
- On reset, all outputs go to 0, the state machine goes to IDLE, and the beat counter and byte mask are cleared.
- Reset during an operation drops mem_req_o immediately. The controller must tolerate an abandoned request.

Beat acceptance:
- A beat is accepted when wb_cyc_i & wb_stb_i & ~wb_ack_o, in a state that takes beats.
- wb_ack_o pulses for exactly one cycle, in the cycle after acceptance.
- wb_ack_o is never high on two consecutive cycles, so the fastest rate is one beat every 2 cycles.

Address and wrap order:
- The first beat latches line = wb_adr_i[AWIDTH-1:2], start = wb_adr_i[1:0] and we = wb_we_i.
- Beat n (n = 0..3) targets word (start+n) mod 4, i.e. critical-word-first wrap.
- Later beats ignore wb_adr_i and wb_we_i.

State machine:
- IDLE: when cyc&stb, latch line, start and we, and clear the mask.
  - we=1: the first beat is accepted in this same cycle; go to WR_BEAT.
  - we=0: go to RD_REQ; no ack yet.
- RD_REQ: mem_req_o=1, mem_we_o=0, mem_adr_o=line.
  - On mem_ack_i, capture mem_rdata_i into the line buffer, set n=0 and go to RD_BEAT.
  - cyc dropping here does not cancel the request. Wait for mem_ack_i, discard the data, go to IDLE.
- RD_BEAT: on each accepted beat, drive wb_dat_o = buffer word (start+n) mod 4 together with wb_ack_o, then n++.
  - After the 4th ack, go to IDLE.
  - If cyc drops, go to IDLE.
- WR_BEAT: on each accepted beat, store wb_dat_i into word (start+n) mod 4 and OR wb_sel_i into that word's mask bits, then ack.
  - After the 4th beat is accepted, go to WR_REQ. The ack is posted: it goes out before the memory commit.
  - If cyc drops with 1 to 3 beats received, go to WR_REQ and commit only the received bytes.
  - If cyc drops with 0 beats received (not reachable from IDLE), go to IDLE.
- WR_REQ: mem_req_o=1, mem_we_o=1, mem_adr_o=line, mem_wdata_o=buffer, mem_be_o=mask. All of these are held stable until mem_ack_i; then go to IDLE.

Ordering and stalls:
- During RD_REQ and WR_REQ no beats are acked, and a new cycle stalls until IDLE. A read that follows a flush therefore sees the flushed data.
- In IDLE, cyc&stb in the cycle right after a burst ends starts a new transaction (back-to-back bursts).

Request timing:
- mem_req_o is registered and rises the cycle after entry to RD_REQ/WR_REQ. It falls the cycle after mem_ack_i.

Test Plan:
- Read, start word 0: controller returns 128'h4444_4444_3333_3333_2222_2222_1111_1111 after 5 cycles -> four acks, spaced 2 cycles apart, carrying 11111111, 22222222, 33333333, 44444444.
- Read, wrap: wb_adr_i=0x1002, rdata as above -> mem_adr_o=0x400; beats return 33333333, 44444444, 11111111, 22222222.
- Write: 4 beats of A0..A3 with sel=F to line 0x80 -> one mem_req_o with we=1, adr 0x80, wdata {A3,A2,A1,A0}, be=16'hFFFF; 4th ack precedes the request.
- Partial write: sel=4'h3 on beat 0, then cyc drops after beat 2 -> be=16'h00F3 (word0 low half, word1 full, words 2/3 off), one request.
- Flush followed by fill: read burst issued while WR_REQ is pending -> no ack until WR_REQ completes; the read's mem_req_o follows the write's mem_ack_i.
- Reset asserted while in RD_REQ -> mem_req_o and wb_ack_o 0 immediately; a subsequent read completes normally.
